// File: rtl/la_gcd_pkg.sv
// Shared constants for the LA-driven Stein GCD accelerator: FSM states,
// logic-analyzer bit positions and default widths.
package la_gcd_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 16;

    localparam int A_LSB     = 0;
    localparam int B_LSB     = 32;
    localparam int START_BIT = 64;
    localparam int RES_LSB   = 0;
    localparam int BUSY_BIT  = 32;
    localparam int DONE_BIT  = 33;
    localparam int CNT_LSB   = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gcd_stein_core.sv
// Binary (Stein) GCD datapath and control, one reduction step per cycle.
// Optional saturating cycle counter enabled by GCD_CYCLE_COUNT_EN.
//
// state | meaning
// IDLE  | reset state, waiting for the first start event
// CALC  | iterating on a/b/k, start events ignored
// DONE  | result and done held until the next start event
module gcd_stein_core
    import la_gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [CNT_W-1:0] cnt_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [5:0]       k_q, k_d;
    logic             busy_q, busy_d, done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    k_d     = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (a_q == '0) begin
                    result_d = b_q << k_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (b_q == '0) begin
                    result_d = a_q << k_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 6'd1;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q >= b_q) begin
                    // Larger operand is always the minuend, so no wrap
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef GCD_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (start_i && state_q != CALC)
            cnt_d = '0;
        else if (state_q == CALC && cnt_q != '1)
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign cnt_o = cnt_q;
`else
    assign cnt_o = '0;
`endif

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: rtl/la_gcd_accel.sv
// LA-bus wrapper for the Stein GCD core: oenb qualification, start edge
// detection and output bit mapping. Optional counter: GCD_CYCLE_COUNT_EN.
module la_gcd_accel
    import la_gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [127:0] la_data_in,
    output logic [127:0] la_data_out,
    input  logic [127:0] la_oenb
);

    logic             start_q, start_d, start_prev_q;
    logic             start_evt;
    logic             busy, done;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt;
    logic             unused_la;

    assign start_d = la_data_in[START_BIT] & ~la_oenb[START_BIT];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            start_q      <= start_d;
            start_prev_q <= start_q;
        end
    end

    assign start_evt = start_q & ~start_prev_q;

    gcd_stein_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .start_i  (start_evt),
        .a_i      (la_data_in[A_LSB +: WIDTH]),
        .b_i      (la_data_in[B_LSB +: WIDTH]),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .cnt_o    (cnt)
    );

    always_comb begin
        la_data_out                      = '0;
        la_data_out[RES_LSB +: WIDTH]    = result;
        la_data_out[BUSY_BIT]            = busy;
        la_data_out[DONE_BIT]            = done;
        la_data_out[CNT_LSB +: CNT_W]    = cnt;
    end

    // Only the start lane of oenb gates anything; other lanes are don't-care
    assign unused_la = ^{la_data_in[127:START_BIT+1], la_oenb[127:START_BIT+1],
                         la_oenb[START_BIT-1:0]};

endmodule

// File: tb/tb_la_gcd_accel.sv
// Directed self-checking bench for la_gcd_accel; counter checks depend on
// whether GCD_CYCLE_COUNT_EN is defined for the build.
module tb_la_gcd_accel;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i = 1'b1;
    logic [127:0] la_data_in = '0;
    logic [127:0] la_data_out;
    logic [127:0] la_oenb = '1;

    int checks = 0;
    int errors = 0;
    int cyc;

    la_gcd_accel dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .la_data_in  (la_data_in),
        .la_data_out (la_data_out),
        .la_oenb     (la_oenb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge wb_clk_i);
    endtask

    task automatic set_start(input logic [31:0] a, input logic [31:0] b);
        la_data_in[31:0]  = a;
        la_data_in[63:32] = b;
        la_data_in[64]    = 1'b1;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (la_data_out[33] !== 1'b1 && n < 80) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk({tag, "_done_seen"}, {31'd0, la_data_out[33]}, 32'd1);
        chk({tag, "_latency_le66"}, {31'd0, (n <= 66)}, 32'd1);
    endtask

    // Start a run, check handshake two cycles after start rises, wait for done
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic [31:0] prev);
        int n;
        set_start(a, b);
        step(2);
        chk({tag, "_busy"}, {31'd0, la_data_out[32]}, 32'd1);
        chk({tag, "_done_clr"}, {31'd0, la_data_out[33]}, 32'd0);
        chk({tag, "_prev_hold"}, la_data_out[31:0], prev);
        la_data_in[64] = 1'b0;
        wait_done(tag, n);
        cyc = n;
        chk({tag, "_result"}, la_data_out[31:0], exp);
        chk({tag, "_busy_off"}, {31'd0, la_data_out[32]}, 32'd0);
    endtask

    initial begin
        la_oenb[64] = 1'b0;
        step(2);
        chk("rst_result", la_data_out[31:0], 32'd0);
        chk("rst_busy", {31'd0, la_data_out[32]}, 32'd0);
        chk("rst_done", {31'd0, la_data_out[33]}, 32'd0);
        chk("rst_cnt", {16'd0, la_data_out[63:48]}, 32'd0);
        wb_rst_i = 1'b0;
        step(1);

        run("r0", 32'd10312050, 32'd29460792, 32'd138, 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
        chk("r0_cnt_nonzero", {31'd0, (la_data_out[63:48] != 16'd0)}, 32'd1);
        chk("r0_cnt_le66", {31'd0, (la_data_out[63:48] <= 16'd66)}, 32'd1);
`else
        chk("r0_cnt_zero", {16'd0, la_data_out[63:48]}, 32'd0);
`endif
        run("r1", 32'd1993627629, 32'd1177417612, 32'd7, 32'd138);
        run("r2", 32'd2097015289, 32'd3812041926, 32'd1, 32'd7);
        run("r3", 32'd1924134885, 32'd3151131255, 32'd135, 32'd1);
        run("r4", 32'd992211318, 32'd512609597, 32'd1, 32'd135);

        run("z00", 32'd0, 32'd0, 32'd0, 32'd1);
        run("z0x", 32'd0, 32'd45, 32'd45, 32'd0);
        chk("z0x_one_cycle", cyc, 32'd1);
`ifdef GCD_CYCLE_COUNT_EN
        chk("z0x_cnt", {16'd0, la_data_out[63:48]}, 32'd1);
`else
        chk("z0x_cnt_zero", {16'd0, la_data_out[63:48]}, 32'd0);
`endif
        run("zx0", 32'd45, 32'd0, 32'd45, 32'd45);
        chk("zx0_one_cycle", cyc, 32'd1);
        run("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd45);
        run("pow2", 32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF);

        // oenb high on the start lane: start must be ignored
        la_oenb[64] = 1'b1;
        set_start(32'd9, 32'd3);
        step(6);
        chk("gate_busy", {31'd0, la_data_out[32]}, 32'd0);
        chk("gate_result", la_data_out[31:0], 32'h4000_0000);
        chk("gate_done", {31'd0, la_data_out[33]}, 32'd1);
        la_data_in[64] = 1'b0;
        step(2);
        la_oenb[64] = 1'b0;
        step(2);
        chk("gate_release_busy", {31'd0, la_data_out[32]}, 32'd0);

        // Start held high across completion must not retrigger
        set_start(32'd6, 32'd4);
        step(2);
        chk("hold_busy", {31'd0, la_data_out[32]}, 32'd1);
        wait_done("hold", cyc);
        chk("hold_result", la_data_out[31:0], 32'd2);
        step(10);
        chk("hold_no_retrig_busy", {31'd0, la_data_out[32]}, 32'd0);
        chk("hold_no_retrig_done", {31'd0, la_data_out[33]}, 32'd1);
        la_data_in[64] = 1'b0;
        step(2);

        // Start pulse and operand change during CALC are ignored
        set_start(32'd10312050, 32'd29460792);
        step(2);
        chk("midpulse_busy", {31'd0, la_data_out[32]}, 32'd1);
        la_data_in[64] = 1'b0;
        step(3);
        set_start(32'd5, 32'd5);
        step(1);
        la_data_in[64] = 1'b0;
        wait_done("midpulse", cyc);
        chk("midpulse_result", la_data_out[31:0], 32'd138);
        step(3);
        chk("midpulse_no_rerun", {31'd0, la_data_out[32]}, 32'd0);

        // Reset mid-CALC aborts to reset values
        set_start(32'd29460792, 32'd10312050);
        step(2);
        chk("abort_busy_before", {31'd0, la_data_out[32]}, 32'd1);
        la_data_in[64] = 1'b0;
        step(3);
        wb_rst_i = 1'b1;
        step(1);
        chk("abort_busy", {31'd0, la_data_out[32]}, 32'd0);
        chk("abort_done", {31'd0, la_data_out[33]}, 32'd0);
        chk("abort_result", la_data_out[31:0], 32'd0);
        chk("abort_cnt", {16'd0, la_data_out[63:48]}, 32'd0);
        wb_rst_i = 1'b0;
        step(2);
        run("post_abort", 32'd29460792, 32'd10312050, 32'd138, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/la_gcd_accel.md
Name: la_gcd_accel

Overview:
- Sequential binary (Stein) GCD accelerator in the Caravel user project area.
- Driven entirely over the logic-analyzer (LA) bus by management-SoC firmware.
- Firmware writes two 32-bit operands and a start bit, polls done, then reads the 32-bit GCD.
- Firmware (not this block) reports progress on mprj_io[31:16] using codes 0xAB40, 0xAB41 and 0xAB51.

Parameters:
- WIDTH, 32, operand/result width. LA map below is fixed for 32; values below 32 zero-extend into the same fields.
- CNT_W, 16, width of the optional cycle counter.

Ports:
- wb_clk_i  input  1  clock; all state on rising edge.
- wb_rst_i  input  1  synchronous active-high reset.
- la_data_in  input  128  [31:0] operand A; [63:32] operand B; [64] start; others ignored.
- la_data_out  output  128  [31:0] result; [32] busy; [33] done; [63:48] cycle count (optional); all other bits 0.
- la_oenb  input  128  active-low mgmt-drive enable; la_oenb[64] must be 0 for start to be honoured.

Behaviour:
- Reset (wb_rst_i=1 at clock edge): state IDLE; result=0, busy=0, done=0, count=0, internal a/b/k=0.
- Start qualification:
  - start_q is la_data_in[64] & ~la_oenb[64], registered once.
  - A start event is a rising edge of start_q, i.e. one cycle after the input rises.
- States:
  - IDLE: wait for start event.
  - CALC: iterate.
  - DONE: hold result.
- IDLE/DONE + start event:
  - Latch a=A, b=B, k=0.
  - Clear done, set busy, go CALC.
  - Start events while in CALC are ignored.
- CALC, one step per cycle, in priority order:
  - a==0: result=b<<k, go DONE.
  - b==0: result=a<<k, go DONE.
  - a and b both even: a>>=1, b>>=1, k++.
  - a even: a>>=1.
  - b even: b>>=1.
  - Both odd and a>=b: a=(a-b)>>1.
  - Both odd and a<b: b=(b-a)>>1.
- Entering DONE: busy=0, done=1. Result and done hold until the next start event or reset.
- Arithmetic:
  - k is 6 bits.
  - Subtraction is unsigned WIDTH-bit with no wrap, since the larger operand is always the minuend.
  - Result shift is combinational at the exit step.
- Latency from start event to done=1 is at most 2*WIDTH+2 cycles (≤66 for WIDTH=32).
- Boundary cases:
  - gcd(0,0)=0.
  - gcd(0,x)=x and gcd(x,0)=x; both complete in 1 CALC cycle.
  - gcd(x,x)=x.
  - Operand inputs are don't-care after latch; changing them mid-CALC has no effect.
- Reset mid-CALC aborts immediately to IDLE with reset values.
- Start held high continuously does not retrigger; it must drop and rise again.

Optional Feature:
- Macro GCD_CYCLE_COUNT_EN.
- When defined:
  - A CNT_W-bit counter clears on each start event and increments every CALC cycle, saturating at all-ones.
  - Its value is driven on la_data_out[63:48] and held in DONE.
- When undefined: no counter logic; la_data_out[63:48]=0.

Decomposition:
- Package la_gcd_pkg:
  - State enum (IDLE, CALC, DONE).
  - LA bit-index constants: A_LSB=0, B_LSB=32, START_BIT=64, RES_LSB=0, BUSY_BIT=32, DONE_BIT=33, CNT_LSB=48.
  - Default WIDTH.
- One natural sub-module, gcd_stein_core: a/b/k datapath and FSM with start/busy/done/result handshake.
- The top-level la_gcd_accel does LA bit mapping, oenb qualification and start edge detection.

Test Plan:
- Reset, then A=10312050, B=29460792, pulse start → busy high 2 cycles after start rises; done within 66 cycles; result=138.
- Back-to-back runs without reset:
  - (1993627629, 1177417612) → 7
  - (2097015289, 3812041926) → 1
  - (1924134885, 3151131255) → 135
  - (992211318, 512609597) → 1
  - For each: done clears on the new start and the previous result holds until overwritten.
- Edge operands: (0,0) → 0; (0,45) → 45; (45,0) → 45; (0xFFFFFFFF,0xFFFFFFFF) → 0xFFFFFFFF; (0x80000000,0x40000000) → 0x40000000.
- Gating and retrigger:
  - start with la_oenb[64]=1 → no activity, busy stays 0.
  - start held high after done → no second run.
  - start pulsed during CALC → ignored; result unchanged.
- Assert wb_rst_i mid-CALC on (29460792,10312050) → next edge: busy=0, done=0, result=0; a following start computes 138 correctly.
- With GCD_CYCLE_COUNT_EN: count for (0,45) is 1; count is nonzero and ≤66 for (10312050,29460792). Without the macro: bits [63:48]=0.
